// File: rtl/sos_cascade_scheduler_if.sv
// Bus bundle for the SOS cascade scheduler: sample in/out handshakes, coefficient
// config port, stage issue/return signals and status.
interface sos_cascade_scheduler_if #(
    parameter int unsigned SEC_W = 2
) ();
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic [15:0]      out_data;
    logic             out_ready;
    logic             cfg_we;
    logic [SEC_W-1:0] cfg_sec;
    logic [2:0]       cfg_idx;
    logic [15:0]      cfg_data;
    logic             gain_we;
    logic             err_clr;
    logic             st_valid;
    logic [15:0]      st_data;
    logic [15:0]      st_b0;
    logic [15:0]      st_b1;
    logic [15:0]      st_b2;
    logic [15:0]      st_a1;
    logic [15:0]      st_a2;
    logic             st_is_last;
    logic [15:0]      st_gain;
    logic             st_valid_out;
    logic [15:0]      st_data_out;
    logic             busy;
    logic [SEC_W-1:0] sec_idx;
    logic             err_timeout;
    logic             cfg_err;

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_sec, cfg_idx, cfg_data, gain_we,
               err_clr, st_valid_out, st_data_out,
        input  in_ready, out_valid, out_data, st_valid, st_data, st_b0, st_b1, st_b2, st_a1,
               st_a2, st_is_last, st_gain, busy, sec_idx, err_timeout, cfg_err
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_sec, cfg_idx, cfg_data, gain_we,
               err_clr, st_valid_out, st_data_out,
        output in_ready, out_valid, out_data, st_valid, st_data, st_b0, st_b1, st_b2, st_a1,
               st_a2, st_is_last, st_gain, busy, sec_idx, err_timeout, cfg_err
    );
endinterface

// File: rtl/sos_cascade_scheduler.sv
// Time-multiplexes one external biquad stage across NUM_SECTIONS cascaded sections,
// holding the per-section coefficient bank and the output gain-correction word.
module sos_cascade_scheduler #(
    parameter int unsigned NUM_SECTIONS = 4,
    parameter int unsigned SEC_W        = 2,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input logic                   clk,
    input logic                   rst,
    sos_cascade_scheduler_if.slave bus
);

    localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NUM_SECTIONS - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e           state;
    logic [SEC_W-1:0] sec_idx;
    logic [TMR_W-1:0] timer;
    logic [15:0]      cur;
    logic             st_valid;
    logic             out_valid;
    logic [15:0]      out_data;
    logic             err_timeout;
    logic             cfg_err;
    logic [15:0]      coef [NUM_SECTIONS][5];
    logic [15:0]      gain;

    logic busy;
    logic in_ready;
    logic cfg_hit;
    logic set_cfg_err;
    logic set_tmo;

    assign busy        = (state != StIdle);
    assign in_ready    = (state == StIdle) && !out_valid;
    assign cfg_hit     = bus.cfg_we && (32'(bus.cfg_sec) < NUM_SECTIONS) && (bus.cfg_idx <= 3'd4);
    assign set_cfg_err = (bus.cfg_we || bus.gain_we) && busy;
    assign set_tmo     = (state == StWait) && !bus.st_valid_out && (timer == TMR_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            sec_idx     <= '0;
            timer       <= '0;
            cur         <= '0;
            st_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err_timeout <= 1'b0;
            cfg_err     <= 1'b0;
            gain        <= 16'h2000;
            for (int s = 0; s < int'(NUM_SECTIONS); s++) begin
                for (int c = 0; c < 5; c++) begin
                    coef[s][c] <= (c == 0) ? 16'h2000 : 16'h0000;
                end
            end
        end else begin
            // A set in the same cycle as a clear must win.
            if (set_cfg_err)      cfg_err <= 1'b1;
            else if (bus.err_clr) cfg_err <= 1'b0;
            if (set_tmo)          err_timeout <= 1'b1;
            else if (bus.err_clr) err_timeout <= 1'b0;

            if (!busy) begin
                if (cfg_hit)     coef[bus.cfg_sec][bus.cfg_idx] <= bus.cfg_data;
                if (bus.gain_we) gain <= bus.cfg_data;
            end

            if (out_valid && bus.out_ready) out_valid <= 1'b0;

            case (state)
                StIdle: begin
                    if (bus.in_valid && in_ready) begin
                        cur      <= bus.in_data;
                        sec_idx  <= '0;
                        st_valid <= 1'b1;
                        state    <= StIssue;
                    end
                end
                StIssue: begin
                    st_valid <= 1'b0;
                    timer    <= '0;
                    state    <= StWait;
                end
                StWait: begin
                    if (bus.st_valid_out) begin
                        cur <= bus.st_data_out;
                        if (sec_idx == LAST_SEC) begin
                            out_data  <= bus.st_data_out;
                            out_valid <= 1'b1;
                            state     <= StIdle;
                        end else begin
                            sec_idx  <= sec_idx + 1'b1;
                            st_valid <= 1'b1;
                            state    <= StIssue;
                        end
                    end else if (timer == TMR_MAX) begin
                        // Lost response: drop the sample without producing output.
                        state <= StIdle;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.st_valid    = st_valid;
    assign bus.st_data     = cur;
    assign bus.st_b0       = coef[sec_idx][0];
    assign bus.st_b1       = coef[sec_idx][1];
    assign bus.st_b2       = coef[sec_idx][2];
    assign bus.st_a1       = coef[sec_idx][3];
    assign bus.st_a2       = coef[sec_idx][4];
    assign bus.st_is_last  = (sec_idx == LAST_SEC);
    assign bus.st_gain     = gain;
    assign bus.busy        = busy;
    assign bus.sec_idx     = sec_idx;
    assign bus.err_timeout = err_timeout;
    assign bus.cfg_err     = cfg_err;

endmodule

// File: tb/tb_sos_cascade_scheduler.sv
// Scoreboard bench for sos_cascade_scheduler with a behavioural stage model
// (y = b0*x in Q2.13, gain applied on the last section).
module tb_sos_cascade_scheduler;

    localparam int N   = 4;
    localparam int TMO = 64;

    logic clk;
    logic rst;

    sos_cascade_scheduler_if #(.SEC_W(2)) bus ();

    sos_cascade_scheduler #(
        .NUM_SECTIONS(N),
        .SEC_W       (2),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          tests     = 0;
    int          fails     = 0;
    int          cyc       = 0;
    int          stage_lat = 6;
    int          drop_sec  = -1;
    int          st_pulses = 0;
    bit          rand_bp   = 0;
    logic [15:0] sh_coef [N][5];
    logic [15:0] sh_gain;
    logic [15:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[28:13];
    endfunction

    // Whole-cascade reference: product of every section's b0, then gain.
    function automatic logic [15:0] ref_cascade(input logic [15:0] x);
        logic [15:0] y;
        y = x;
        for (int s = 0; s < N; s++) y = qmul(sh_coef[s][0], y);
        return qmul(sh_gain, y);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic shadow_defaults();
        for (int s = 0; s < N; s++)
            for (int c = 0; c < 5; c++) sh_coef[s][c] = (c == 0) ? 16'h2000 : 16'h0000;
        sh_gain = 16'h2000;
    endtask

    task automatic cfg_write(input bit we, input bit gwe, input int sec, input int idx,
                             input logic [15:0] d, input bit taken);
        bus.cfg_we   = we;
        bus.gain_we  = gwe;
        bus.cfg_sec  = 2'(sec);
        bus.cfg_idx  = 3'(idx);
        bus.cfg_data = d;
        tick();
        bus.cfg_we  = 1'b0;
        bus.gain_we = 1'b0;
        if (taken) begin
            if (we && sec < N && idx <= 4) sh_coef[sec][idx] = d;
            if (gwe) sh_gain = d;
        end
    endtask

    task automatic send(input logic [15:0] x, input bit push, output int acc);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        while (bus.in_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL send_accept: in_ready never rose, got %0d cycles, expected < 2000", n);
        end
        acc = cyc + 1;
        if (push) exp_q.push_back(ref_cascade(x));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int acc, output int lat);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        lat = cyc - acc + 1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    // Stage model: one outstanding request, answers stage_lat cycles after st_valid.
    initial begin : stage_model
        logic [15:0] x, b, g, y;
        logic        last;
        bit          drop;
        bus.st_valid_out = 1'b0;
        bus.st_data_out  = '0;
        forever begin
            @(negedge clk);
            bus.st_valid_out = 1'b0;
            if (bus.st_valid === 1'b1) begin
                x    = bus.st_data;
                b    = bus.st_b0;
                g    = bus.st_gain;
                last = bus.st_is_last;
                drop = (int'(bus.sec_idx) == drop_sec);
                y    = qmul(b, x);
                if (last) y = qmul(g, y);
                repeat (stage_lat) @(negedge clk);
                if (!drop) begin
                    bus.st_valid_out = 1'b1;
                    bus.st_data_out  = y;
                end
            end
        end
    end

    // Every issue must present the shadow bank entry of the current section.
    initial begin : issue_checker
        int s;
        forever begin
            @(negedge clk);
            #1;
            if (bus.st_valid === 1'b1) begin
                st_pulses++;
                s = int'(bus.sec_idx);
                check("issue_is_last", 32'(bus.st_is_last), 32'(s == N - 1));
                check("issue_b0", 32'(bus.st_b0), 32'(sh_coef[s][0]));
                check("issue_b1", 32'(bus.st_b1), 32'(sh_coef[s][1]));
                check("issue_b2", 32'(bus.st_b2), 32'(sh_coef[s][2]));
                check("issue_a1", 32'(bus.st_a1), 32'(sh_coef[s][3]));
                check("issue_a2", 32'(bus.st_a2), 32'(sh_coef[s][4]));
                check("issue_gain", 32'(bus.st_gain), 32'(sh_gain));
            end
        end
    end

    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got out_data 0x%0h, expected no output",
                             bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_out_data", 32'(bus.out_data), 32'(e));
                end
            end
        end
    end

    initial begin : backpressure
        forever begin
            @(negedge clk);
            if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc, lat, n;
        logic [15:0] d0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.gain_we  = 1'b0;
        bus.cfg_sec  = '0;
        bus.cfg_idx  = '0;
        bus.cfg_data = '0;
        bus.err_clr  = 1'b0;
        shadow_defaults();
        tick(2);
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_st_data", 32'(bus.st_data), 0);
        check("rst_st_valid", 32'(bus.st_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_sec_idx", 32'(bus.sec_idx), 0);
        check("rst_errs", {30'd0, bus.err_timeout, bus.cfg_err}, 0);
        check("rst_b0", 32'(bus.st_b0), 32'h2000);
        check("rst_a2", 32'(bus.st_a2), 0);
        check("rst_gain", 32'(bus.st_gain), 32'h2000);

        // 1: defaults, latency and pulse count
        st_pulses = 0;
        send(16'h1000, 1, acc);
        wait_out(acc, lat);
        check("t1_latency", lat, N * (stage_lat + 1) + 1);
        check("t1_pulses", st_pulses, N);
        check("t1_out_data", 32'(bus.out_data), 32'h1000);
        tick();

        // 2: section 2 b0 = 2.0, gain = 0.5
        cfg_write(1, 0, 2, 0, 16'h4000, 1);
        cfg_write(0, 1, 0, 0, 16'h1000, 1);
        send(16'h0800, 1, acc);
        wait_out(acc, lat);
        check("t2_out_data", 32'(bus.out_data), 32'h0800);
        tick();

        // 3: output backpressure with a pending input
        bus.out_ready = 1'b0;
        send(16'h0400, 1, acc);
        wait_out(acc, lat);
        d0 = bus.out_data;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0100;
        st_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_data", 32'(bus.out_data), 32'(d0));
            check("t3_hold_valid", 32'(bus.out_valid), 1);
            check("t3_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        check("t3_in_ready_release", 32'(bus.in_ready), 0);
        tick();
        check("t3_out_valid_cleared", 32'(bus.out_valid), 0);
        check("t3_in_ready_after", 32'(bus.in_ready), 1);
        check("t3_no_early_issue", st_pulses, 0);
        send(16'h0100, 1, acc);
        wait_out(acc, lat);
        tick();

        // 4: lost response on section 1
        drop_sec = 1;
        send(16'h0200, 0, acc);
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check("t4_timeout_cycle", cyc - acc + 1, stage_lat + 67);
        check("t4_err_timeout", 32'(bus.err_timeout), 1);
        check("t4_in_ready", 32'(bus.in_ready), 1);
        check("t4_no_output", 32'(bus.out_valid), 0);
        drop_sec = -1;
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("t4_err_cleared", 32'(bus.err_timeout), 0);

        // 5: write while busy is dropped and flagged
        send(16'h0300, 1, acc);
        tick(3);
        cfg_write(1, 0, 0, 1, 16'h1234, 0);
        check("t5_cfg_err", 32'(bus.cfg_err), 1);
        wait_out(acc, lat);
        tick();
        send(16'h0300, 1, acc);
        check("t5_sec_idx", 32'(bus.sec_idx), 0);
        check("t5_st_b1", 32'(bus.st_b1), 0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("t5_cfg_err_cleared", 32'(bus.cfg_err), 0);
        wait_out(acc, lat);
        tick();

        // 6: reset during WAIT of section 2
        wait_idle();
        cfg_write(1, 0, 0, 0, 16'h3000, 1);
        send(16'h0500, 0, acc);
        n = 0;
        while (!(bus.sec_idx == 2'd2 && bus.busy && !bus.st_valid) && n < 500) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        shadow_defaults();
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_st_valid", 32'(bus.st_valid), 0);
        check("t6_out_valid", 32'(bus.out_valid), 0);
        check("t6_sec_idx", 32'(bus.sec_idx), 0);
        check("t6_b0_default", 32'(bus.st_b0), 32'h2000);
        check("t6_gain_default", 32'(bus.st_gain), 32'h2000);
        tick(stage_lat + 3);
        check("t6_stale_ignored", {30'd0, bus.out_valid, bus.busy}, 0);
        send(16'h0700, 1, acc);
        wait_out(acc, lat);
        check("t6_latency", lat, N * (stage_lat + 1) + 1);
        tick();

        // Randomised traffic with config churn and backpressure
        rand_bp = 1'b1;
        for (int t = 0; t < 40; t++) begin
            wait_idle();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                int sec, idx;
                logic [15:0] d;
                sec = int'($urandom_range(0, N - 1));
                idx = int'($urandom_range(0, 7));
                d   = (idx == 0) ? 16'($urandom_range(16'h1000, 16'h3000)) : 16'($urandom);
                if ($urandom_range(0, 3) == 0)
                    cfg_write(1, 1, sec, idx, 16'($urandom_range(16'h1000, 16'h3000)), 1);
                else
                    cfg_write(1, 0, sec, idx, d, 1);
            end
            stage_lat = int'($urandom_range(1, 8));
            send(16'($urandom), 1, acc);
        end
        rand_bp = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
